// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Used by dmem_arbiter, its interface and the bench.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  function automatic int next_ptr(
    input int idx,
    input int n
  );
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester/memory bundle of the data-memory arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      lock_abort;

  modport slave (
    input  req_valid, req_we, req_lock,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, lock_abort
  );

  modport master (
    output req_valid, req_we, req_lock,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, lock_abort
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Rotating-priority picker: first request at or after
// ptr_i, wrapping; one-hot grant plus encoded index.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // upper segment [ptr..N-1] first, then the wrap
    for (int j = 0; j < N; j++) begin
      if (!any_o && req_i[j] && j >= int'(ptr_i)) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any_o && req_i[j] && j < int'(ptr_i)) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter with bounded RMW lock.
// Define DMEM_ARB_CPU_PRIO_EN to give requester 0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input logic     clk,
  input logic     rst,
  dmem_arb_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               abort_q, abort_d;

  logic [NUM_REQ-1:0] rr_req, rr_gnt;
  logic [IW-1:0]      rr_idx, gnt_idx;
  logic               rr_any, gnt_any;
  logic               release_acc;
  logic [NUM_REQ-1:0] rsp_vld;

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign rr_req = bus.req_valid & ~NUM_REQ'(1);
`else
  assign rr_req = bus.req_valid;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
`ifdef DMEM_ARB_CPU_PRIO_EN
          if (bus.req_valid[0]) begin
            gnt_any = 1'b1;
          end else
`endif
          begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
          end
        end
        ARB_LOCKED: begin
          gnt_any = bus.req_valid[owner_q];
          gnt_idx = owner_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = gnt_any ?
    (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.mem_en    = gnt_any;
  assign bus.mem_we    = gnt_any & bus.req_we[gnt_idx];
  assign bus.mem_addr  = gnt_any ?
    bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_wdata = gnt_any ?
    bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;

  // a response still in flight is hidden while reset is held
  assign rsp_vld        = rsp_q & {NUM_REQ{~rst}};
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_rdata  = (|rsp_vld) ? bus.mem_rdata : hold_q;
  assign bus.lock_abort = abort_q;

  assign release_acc = gnt_any && !bus.req_lock[owner_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    rsp_d   = (gnt_any && !bus.mem_we) ? bus.req_ready : '0;
    hold_d  = (|rsp_vld) ? bus.mem_rdata : hold_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_any) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
          if (gnt_idx != '0)
`endif
          ptr_d = IW'(next_ptr(int'(gnt_idx), NUM_REQ));
          if (bus.req_lock[gnt_idx]) begin
            state_d = ARB_LOCKED;
            owner_d = gnt_idx;
            cnt_d   = CW'(1);
          end
        end
      end
      ARB_LOCKED: begin
        cnt_d = cnt_q + 1'b1;
        if (release_acc || int'(cnt_q) == MAX_LOCK) begin
          state_d = ARB_IDLE;
          ptr_d   = IW'(next_ptr(int'(owner_q), NUM_REQ));
          cnt_d   = '0;
          abort_d = !release_acc;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
      hold_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      hold_q  <= hold_d;
      abort_q <= abort_d;
    end
  end

endmodule
